// File: rtl/iter_div_pkg.sv
// Shared definitions for the iterative restoring divider: datapath width,
// FSM state encoding and a magnitude helper for signed operands.
package iter_div_pkg;

  localparam int DIV_W = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Absolute value when the operand is treated as signed; |0x80000000| wraps
  // to 0x80000000, which is the correct unsigned magnitude.
  function automatic logic [DIV_W-1:0] div_mag(input logic [DIV_W-1:0] v,
                                               input logic is_signed);
    return (is_signed && v[DIV_W-1]) ? (~v + DIV_W'(1)) : v;
  endfunction

endpackage

// File: rtl/iter_div_step.sv
// One restoring-division iteration (div_step): shift the next dividend bit into
// the partial remainder and subtract the divisor magnitude when it fits.
module iter_div_step
  import iter_div_pkg::*;
(
  input  logic [DIV_W-1:0] rem_in,
  input  logic             bit_in,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] rem_out,
  output logic             q_bit
);

  logic [DIV_W:0] partial;

  // 33-bit trial compare; the low 32 bits of the difference are exact because
  // the result is always smaller than the divisor.
  always_comb begin
    partial = {rem_in, bit_in};
    q_bit   = (partial >= {1'b0, divisor});
    rem_out = q_bit ? (partial[DIV_W-1:0] - divisor) : partial[DIV_W-1:0];
  end

endmodule

// File: rtl/iter_div.sv
// Multi-cycle radix-2 restoring divider with independent dividend/divisor
// stream channels and a one-cycle {remainder, quotient} result strobe.
//
// Handshake: a channel transfers on a rising edge where tvalid && tready;
// tready is high only in IDLE while that channel has not yet captured an
// operand. The result channel has no tready: the consumer must take the data
// in the single cycle m_axis_dout_tvalid is high.
module iter_div
  import iter_div_pkg::*;
#(
  parameter int SIGNED = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [DIV_W-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  input  logic [DIV_W-1:0]   s_axis_divisor_tdata,
  input  logic               cancel,
  output logic               m_axis_dout_tvalid,
  output logic [2*DIV_W-1:0] m_axis_dout_tdata,
  output logic [1:0]         dbg_state
);

  localparam logic IS_SIGNED = (SIGNED != 0);

  div_state_t       state;
  logic             dvd_held, dvs_held;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] a_sh;     // dividend magnitude, shifts out MSB-first, quotient shifts in
  logic [DIV_W-1:0] b_mag;
  logic [DIV_W-1:0] rem;
  logic             sa, sb;

  logic             dvd_xfer, dvs_xfer;
  logic [DIV_W-1:0] rem_nxt;
  logic             q_bit;
  logic [DIV_W-1:0] q_final, res_q, res_r;

  assign s_axis_dividend_tready = (state == DIV_IDLE) && !dvd_held;
  assign s_axis_divisor_tready  = (state == DIV_IDLE) && !dvs_held;
  assign dvd_xfer  = s_axis_dividend_tvalid && s_axis_dividend_tready;
  assign dvs_xfer  = s_axis_divisor_tvalid  && s_axis_divisor_tready;
  assign dbg_state = state;

  iter_div_step u_step (
    .rem_in  (rem),
    .bit_in  (a_sh[DIV_W-1]),
    .divisor (b_mag),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  // Final-iteration result with sign fix-up: quotient sign is sa^sb,
  // remainder takes the dividend's sign. Divide-by-zero falls out naturally.
  always_comb begin
    q_final = {a_sh[DIV_W-2:0], q_bit};
    res_q   = (sa ^ sb) ? (~q_final + DIV_W'(1)) : q_final;
    res_r   = sa ? (~rem_nxt + DIV_W'(1)) : rem_nxt;
  end

  // FSM, operand capture, iteration and registered result; cancel beats everything but reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state              <= DIV_IDLE;
      dvd_held           <= 1'b0;
      dvs_held           <= 1'b0;
      cnt                <= '0;
      a_sh               <= '0;
      b_mag              <= '0;
      rem                <= '0;
      sa                 <= 1'b0;
      sb                 <= 1'b0;
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tdata  <= '0;
    end else if (cancel) begin
      state              <= DIV_IDLE;
      dvd_held           <= 1'b0;
      dvs_held           <= 1'b0;
      cnt                <= '0;
      m_axis_dout_tvalid <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          rem <= '0;
          cnt <= '0;
          if (dvd_xfer) begin
            a_sh     <= div_mag(s_axis_dividend_tdata, IS_SIGNED);
            sa       <= IS_SIGNED && s_axis_dividend_tdata[DIV_W-1];
            dvd_held <= 1'b1;
          end
          if (dvs_xfer) begin
            b_mag    <= div_mag(s_axis_divisor_tdata, IS_SIGNED);
            sb       <= IS_SIGNED && s_axis_divisor_tdata[DIV_W-1];
            dvs_held <= 1'b1;
          end
          if ((dvd_held || dvd_xfer) && (dvs_held || dvs_xfer)) begin
            state <= DIV_CALC;
          end
        end
        DIV_CALC: begin
          rem  <= rem_nxt;
          a_sh <= q_final;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DIV_W - 1)) begin
            m_axis_dout_tdata  <= {res_r, res_q};
            m_axis_dout_tvalid <= 1'b1;
            state              <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          m_axis_dout_tvalid <= 1'b0;
          dvd_held           <= 1'b0;
          dvs_held           <= 1'b0;
          state              <= DIV_IDLE;
        end
        default: begin
          state <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div.sv
// Directed-vector bench for iter_div: one unsigned (index 0) and one signed
// (index 1) instance, scoreboard queue filled at issue, monitor pops on strobe.
module tb_iter_div;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic        cancel      [2];
  logic        dvd_tvalid  [2];
  logic        dvd_tready  [2];
  logic [31:0] dvd_tdata   [2];
  logic        dvs_tvalid  [2];
  logic        dvs_tready  [2];
  logic [31:0] dvs_tdata   [2];
  logic        dout_tvalid [2];
  logic [63:0] dout_tdata  [2];
  logic [1:0]  dbg_state   [2];

  iter_div #(.SIGNED(0)) u_div_u (
    .clk                    (clk),
    .resetn                 (resetn),
    .s_axis_dividend_tvalid (dvd_tvalid[0]),
    .s_axis_dividend_tready (dvd_tready[0]),
    .s_axis_dividend_tdata  (dvd_tdata[0]),
    .s_axis_divisor_tvalid  (dvs_tvalid[0]),
    .s_axis_divisor_tready  (dvs_tready[0]),
    .s_axis_divisor_tdata   (dvs_tdata[0]),
    .cancel                 (cancel[0]),
    .m_axis_dout_tvalid     (dout_tvalid[0]),
    .m_axis_dout_tdata      (dout_tdata[0]),
    .dbg_state              (dbg_state[0])
  );

  iter_div #(.SIGNED(1)) u_div_s (
    .clk                    (clk),
    .resetn                 (resetn),
    .s_axis_dividend_tvalid (dvd_tvalid[1]),
    .s_axis_dividend_tready (dvd_tready[1]),
    .s_axis_dividend_tdata  (dvd_tdata[1]),
    .s_axis_divisor_tvalid  (dvs_tvalid[1]),
    .s_axis_divisor_tready  (dvs_tready[1]),
    .s_axis_divisor_tdata   (dvs_tdata[1]),
    .cancel                 (cancel[1]),
    .m_axis_dout_tvalid     (dout_tvalid[1]),
    .m_axis_dout_tdata      (dout_tdata[1]),
    .dbg_state              (dbg_state[1])
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int          exp_dut_q[$];
  int          exp_cyc_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Strobe lands 33 cycles after the edge that completes the last transfer;
  // the monitor samples on negedge, when cyc counts edges seen so far.
  task automatic expect_res(input int d, input logic [63:0] e);
    exp_q.push_back(e);
    exp_dut_q.push_back(d);
    exp_cyc_q.push_back(cyc + 33);
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      for (int d = 0; d < 2; d++) begin
        if (dout_tvalid[d]) begin
          if (exp_q.size() == 0 || exp_dut_q[0] != d) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_strobe dut%0d: actual=strobe data=%h required=no strobe (cycle %0d)",
                     d, dout_tdata[d], cyc);
          end else begin
            check("dout_tdata", dout_tdata[d], exp_q[0]);
            check("strobe_latency", 64'(cyc), 64'(exp_cyc_q[0]));
            void'(exp_q.pop_front());
            void'(exp_dut_q.pop_front());
            void'(exp_cyc_q.pop_front());
          end
        end
      end
      if (exp_q.size() > 0 && cyc > exp_cyc_q[0]) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missed_strobe dut%0d: actual=no strobe required=%h by cycle %0d",
                 exp_dut_q[0], exp_q[0], exp_cyc_q[0]);
        void'(exp_q.pop_front());
        void'(exp_dut_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer operands on the chosen instance for exactly one edge.
  task automatic drive(input int d, input logic dv, input logic [31:0] a,
                       input logic sv, input logic [31:0] b);
    dvd_tvalid[d] = dv;
    dvd_tdata[d]  = a;
    dvs_tvalid[d] = sv;
    dvs_tdata[d]  = b;
    step();
    dvd_tvalid[d] = 1'b0;
    dvs_tvalid[d] = 1'b0;
  endtask

  // Wait (bounded) until every queued result has been seen, then confirm the
  // strobe has already dropped one cycle after it rose.
  task automatic drain(input int d);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    step();
    check("strobe_width", 64'(dout_tvalid[d]), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag, input int d, input logic [63:0] dout);
    check({tag, "_dvd_tready"}, 64'(dvd_tready[d]), 64'd1);
    check({tag, "_dvs_tready"}, 64'(dvs_tready[d]), 64'd1);
    check({tag, "_tvalid"}, 64'(dout_tvalid[d]), 64'd0);
    check({tag, "_tdata"}, dout_tdata[d], dout);
  endtask

  // ---------------- stimulus ----------------
  int t1, t2;

  initial begin
    for (int d = 0; d < 2; d++) begin
      cancel[d]     = 1'b0;
      dvd_tvalid[d] = 1'b0;
      dvd_tdata[d]  = '0;
      dvs_tvalid[d] = 1'b0;
      dvs_tdata[d]  = '0;
    end
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    // reset values on both instances
    for (int d = 0; d < 2; d++) begin
      check_idle_outputs("reset", d, 64'h0);
      check("reset_state", 64'(dbg_state[d]), 64'd0);
    end

    // unsigned 100 / 7, both channels together
    expect_res(0, {32'h0000_0002, 32'h0000_000E});
    drive(0, 1'b1, 32'd100, 1'b1, 32'd7);
    drain(0);

    // signed -7 / 2, dividend first, divisor three cycles later
    drive(1, 1'b1, 32'hFFFF_FFF9, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      check("held_dvd_tready", 64'(dvd_tready[1]), 64'd0);
      check("held_dvs_tready", 64'(dvs_tready[1]), 64'd1);
      step();
    end
    expect_res(1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    drive(1, 1'b0, 32'h0, 1'b1, 32'd2);
    check("calc_dvd_tready", 64'(dvd_tready[1]), 64'd0);
    check("calc_dvs_tready", 64'(dvs_tready[1]), 64'd0);
    drain(1);

    // signed overflow: most-negative / -1 wraps
    expect_res(1, {32'h0000_0000, 32'h8000_0000});
    drive(1, 1'b1, 32'h8000_0000, 1'b1, 32'hFFFF_FFFF);
    drain(1);

    // signed divide by zero, negative dividend
    expect_res(1, {32'hFFFF_FFFB, 32'h0000_0001});
    drive(1, 1'b1, 32'hFFFF_FFFB, 1'b1, 32'h0);
    drain(1);

    // unsigned divide by zero
    expect_res(0, {32'h0000_1234, 32'hFFFF_FFFF});
    drive(0, 1'b1, 32'h0000_1234, 1'b1, 32'h0);
    drain(0);

    // cancel at CALC iteration 10: no strobe, ready next cycle, dout held
    drive(0, 1'b1, 32'd50, 1'b1, 32'd5);
    repeat (10) step();
    check("pre_cancel_state", 64'(dbg_state[0]), 64'd1);
    cancel[0] = 1'b1;
    step();
    cancel[0] = 1'b0;
    check_idle_outputs("cancel", 0, {32'h0000_1234, 32'hFFFF_FFFF});
    check("cancel_state", 64'(dbg_state[0]), 64'd0);
    repeat (40) step();

    // transfer offered alongside cancel in IDLE is discarded
    cancel[0] = 1'b1;
    drive(0, 1'b1, 32'd77, 1'b0, 32'h0);
    cancel[0] = 1'b0;
    check("cancel_discard_dvd_tready", 64'(dvd_tready[0]), 64'd1);

    expect_res(0, {32'h0000_0000, 32'h0000_0003});
    drive(0, 1'b1, 32'd9, 1'b1, 32'd3);
    drain(0);

    // reset during CALC: no strobe, outputs back to reset values
    drive(1, 1'b1, 32'd20, 1'b1, 32'd4);
    repeat (5) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check_idle_outputs("midreset", 1, 64'h0);
    check("midreset_state", 64'(dbg_state[1]), 64'd0);
    repeat (40) step();

    // back-to-back requests 34 cycles apart
    expect_res(1, {32'h0000_0000, 32'h0000_0064});
    t1 = cyc + 1;
    drive(1, 1'b1, 32'd1000, 1'b1, 32'd10);
    for (int i = 0; i < 60; i++) begin
      if (dvd_tready[1] && dvs_tready[1]) break;
      step();
    end
    expect_res(1, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    t2 = cyc + 1;
    drive(1, 1'b1, 32'hFFFF_FF9C, 1'b1, 32'd7);
    check("b2b_spacing", 64'(t2 - t1), 64'd34);
    drain(1);

    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iter_div.md
# iter_div

Multi-cycle radix-2 restoring divider that serves the execute stage's divide requests over the same two-operand AXI-stream-style handshake (dividend channel, divisor channel, result channel). It replaces the vendor `div_signed`/`div_unsigned` IP with in-house RTL. One instance is built per signedness. It accepts operands independently, computes for a fixed 32 cycles, and emits a one-cycle result pulse carrying {remainder, quotient}.

## Interface
- `SIGNED`, default 1: 1 = two's-complement divide, 0 = unsigned divide.
- `clk` in 1: sole clock.
- `resetn` in 1: synchronous, active-low reset.
- `s_axis_dividend_tvalid` in 1: dividend offered.
- `s_axis_dividend_tready` out 1: dividend channel can capture.
- `s_axis_dividend_tdata` in 32: dividend.
- `s_axis_divisor_tvalid` in 1: divisor offered.
- `s_axis_divisor_tready` out 1: divisor channel can capture.
- `s_axis_divisor_tdata` in 32: divisor.
- `cancel` in 1: abort any pending or in-flight operation (pipeline flush).
- `m_axis_dout_tvalid` out 1: one-cycle result strobe.
- `m_axis_dout_tdata` out 64: [63:32] remainder, [31:0] quotient.

## Operation
- Clock and reset are as decided: one clock, reset synchronous and active-low (`clk`, `resetn`).
- **States:**
  - IDLE: collecting operands.
  - CALC: 32 iterations.
  - DONE: result strobe.
- **IDLE:**
  - Each channel has a held flag. `tready` = IDLE && !held for that channel.
  - A channel transfers when tvalid && tready. Its data is registered and its flag is set.
  - The two channels may transfer in the same cycle or in different cycles, in either order.
  - When both flags are set (at the end of the cycle the second transfer completes), the block goes to CALC.
- **Start of CALC:**
  - SIGNED=1: latch the sign of the dividend (sa) and the sign of the divisor (sb). Operate on the magnitudes |a| and |b| (32-bit unsigned; |0x80000000| = 0x80000000).
  - SIGNED=0: the magnitudes are the raw operands.
- **Each CALC cycle:**
  - Form partial remainder {r[31:0], next dividend bit}, 33 bits wide.
  - If it is ≥ {1'b0, |b|}, subtract |b| and shift in quotient bit 1; otherwise shift in 0.
  - Iteration counter runs 0..31. At 31 the block goes to DONE.
- **DONE:**
  - Sign fix-up (SIGNED=1): quotient negated if sa^sb; remainder negated if sa.
  - The result is registered into `m_axis_dout_tdata`. `m_axis_dout_tvalid`=1 for exactly this cycle.
  - Both held flags are cleared and the block returns to IDLE.
- **Arithmetic boundary results:**
  - Unsigned divide-by-zero: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed divide-by-zero: quotient = 0x00000001 if dividend < 0, else 0xFFFFFFFF; remainder = dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000 (wraps), remainder 0.
- **`cancel`:**
  - Highest priority. In any state it clears both held flags and the counter and forces IDLE on the next edge.
  - No dout strobe is issued.
  - A transfer offered in the same cycle as `cancel` is discarded.
  - `m_axis_dout_tdata` keeps its previous value.
- No result backpressure: the consumer must sample the strobe cycle.

## Timing
- **Reset values:**
  - IDLE, flags clear, counter 0.
  - `s_axis_*_tready`=1 (combinational from IDLE and the flags; both read 1 in the first cycle after reset).
  - `m_axis_dout_tvalid`=0, `m_axis_dout_tdata`=0.
- **Latency:** if the last operand transfers at edge T, CALC occupies cycles T+1..T+32 and `m_axis_dout_tvalid`=1 in cycle T+33. The cycle count is fixed and independent of data.
- **Throughput:** a new operand transfer is possible in the cycle after the DONE cycle, so back-to-back operations are 34 cycles apart.
- Both `tready` are 0 throughout CALC and DONE.
- `m_axis_dout_tdata` changes only on entry to DONE and is stable otherwise.
- **Reset mid-operation** (resetn low in CALC or DONE): IDLE on that edge; no strobe.

## Structure
- Shared header `mycpu.h`:
  - `` `DIV_W `` (32).
  - State encodings `` `DIV_IDLE ``/`` `DIV_CALC ``/`` `DIV_DONE `` (2-bit).
- One sub-module, `div_step`: a combinational single restoring iteration.
  - Inputs: 32-bit partial remainder, incoming dividend bit, divisor magnitude.
  - Outputs: next remainder, quotient bit.
- The top level holds the FSM, held flags, counter, operand/sign registers and the output register.

## Test plan
- Unsigned, both channels transfer in the same cycle, 100 / 7 → strobe exactly 33 cycles later, dout = {0x00000002, 0x0000000E}; the strobe is 1 cycle wide.
- Signed, dividend first, divisor 3 cycles later, -7 / 2 → dout = {0xFFFFFFFF, 0xFFFFFFFD}; the dividend `tready` is low between the two transfers.
- Signed boundary cases:
  - 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}.
  - -5 / 0 → {0xFFFFFFFB, 0x00000001}.
- Unsigned divide-by-zero: 0x1234 / 0 → {0x00001234, 0xFFFFFFFF}.
- `cancel` asserted at CALC iteration 10 → no strobe, `tready` returns to 1 next cycle, prior dout held; a fresh 9/3 then yields {0, 3}.
- `resetn` low during CALC → no strobe, all outputs at reset values; 34-cycle back-to-back spacing is verified on two consecutive requests.
